// File: rtl/cmp_iter.sv
// Iterative chunk-serial comparator: walks operands MSB chunk first, stopping at
// the first differing chunk, and reports EQ/NE/LT/GE (signed/unsigned) or MIN/MAX.
module cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       function_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic [WIDTH-1:0] value
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_sel;
  logic [IDXW-1:0]  r_idx;
  logic             r_result;
  logic [WIDTH-1:0] r_value;

  logic [CHUNK-1:0] w_a_chunk, w_b_chunk;
  logic             w_accept, w_differ, w_last, w_less, w_equal, w_a_sel, w_result;
  logic [WIDTH-1:0] w_value;

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign value     = r_value;
  assign w_accept  = in_valid && in_ready;

  // Flipping the MSB of the top chunk turns a two's-complement order into an unsigned one.
  always_comb begin
    w_a_chunk = CHUNK'(r_a >> (32'(r_idx) * CHUNK));
    w_b_chunk = CHUNK'(r_b >> (32'(r_idx) * CHUNK));
    if (r_sel[1] && (r_idx == TOP_IDX)) begin
      w_a_chunk[CHUNK-1] = ~w_a_chunk[CHUNK-1];
      w_b_chunk[CHUNK-1] = ~w_b_chunk[CHUNK-1];
    end
  end

  always_comb begin
    w_differ = (w_a_chunk != w_b_chunk);
    w_last   = (r_idx == '0);
    w_less   = w_differ && (w_a_chunk < w_b_chunk);
    w_equal  = !w_differ;
    w_a_sel  = r_sel[0] ? !w_less : (w_less || w_equal);
    w_result = r_sel[3] ? w_a_sel : (r_sel[0] ^ (r_sel[2] ? w_less : w_equal));
    w_value  = r_sel[3] ? (w_a_sel ? r_a : r_b) : '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_COMPARE;
      S_COMPARE: if (w_differ || w_last) w_next = S_DONE;
      S_DONE:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= '0;
      r_idx    <= '0;
      r_result <= 1'b0;
      r_value  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= input_a;
        r_b   <= input_b;
        r_sel <= function_select;
        r_idx <= TOP_IDX;
      end
      if (r_state == S_COMPARE) begin
        if (w_differ || w_last) begin
          r_result <= w_result;
          r_value  <= w_value;
        end else begin
          r_idx <= r_idx - 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/cmp_iter.md
CMP_ITER -- requirements
Module: cmp_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter CHUNK, default 8: bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 Derived NCHUNK = WIDTH/CHUNK: maximum compare cycles.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operands and function_select are valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 input_a  input  WIDTH  first operand.
REQ-009 input_b  input  WIDTH  second operand.
REQ-010 function_select  input  4  [3] minmax, [2] less, [1] sign, [0] negate.
REQ-011 out_valid  output  1  result and value are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  1  comparison outcome.
REQ-014 value  output  WIDTH  min/max operand in minmax mode; 0 otherwise.

Function
REQ-015 States: IDLE, COMPARE and DONE; reset SHALL force IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE with reset low; a request SHALL be accepted on an edge with in_valid & in_ready, which latches the operands and function_select, loads the chunk index to NCHUNK-1, and enters COMPARE.
REQ-017 COMPARE: each cycle compares chunk[idx] of the latched operands, MSB chunk first; for the top chunk with sign=1, the operand MSBs SHALL be inverted before an unsigned compare.
REQ-018 Chunk differs: decide less = (a_chunk < b_chunk), equal = 0, and go to DONE at the next edge (early termination).
REQ-019 Chunk equal with idx > 0: decrement idx and stay in COMPARE.
REQ-020 Chunk equal with idx == 0: decide less = 0, equal = 1, and go to DONE.
REQ-021 Latency from the accept edge to out_valid SHALL be k cycles, where k = number of chunks examined (1..NCHUNK).
REQ-022 In minmax = 0 mode:
- result = negate XOR (less ? is_less : is_equal).
- value = 0.
REQ-023 In minmax = 1 mode:
- sign selects signed vs unsigned ordering; negate = 0 selects MIN, negate = 1 selects MAX.
- value = the selected latched operand; on a tie, value = input_a.
- result = 1 when input_a is the selected operand (input_a selected, or a tie), else 0.
- less is ignored.
REQ-024 DONE: out_valid = 1; result and value SHALL remain stable until out_valid & out_ready, then the block returns to IDLE at that edge.
REQ-025 A new request SHALL NOT be accepted in the same cycle the result is consumed; the earliest next accept is the following cycle.
REQ-026 result and value SHALL be registered; out_valid and in_ready SHALL be decoded from state only.
REQ-027 Operand inputs changing after the accept edge SHALL NOT affect the in-flight operation.

Reset
REQ-028 At the reset edge: state = IDLE, out_valid = 0, result = 0, value = 0, and the index and operand registers are cleared.
REQ-029 Reset asserted mid-COMPARE or in DONE SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 the cycle after reset deasserts.
REQ-030 in_valid SHALL be ignored while reset is high.

Verification
REQ-031 Signed LT (sel = 4'b0110), a = 0xFFFFFFFF (-1), b = 0x00000001 -> result = 1 after 1 compare cycle; unsigned LTU (sel = 4'b0100) on the same operands -> result = 0, 1 cycle.
REQ-032 EQ (sel = 4'b0000) and NE (sel = 4'b0001), a = b = 0x12345678 -> EQ result = 1, NE result = 0, each after 4 cycles; a = 0x12345679, b = 0x12345678 -> EQ result = 0 after 4 cycles.
REQ-033 MAX signed (sel = 4'b1011), a = 0x80000000, b = 0x7FFFFFFF -> value = 0x7FFFFFFF, result = 0; MINU (sel = 4'b1000), same operands -> value = 0x7FFFFFFF, result = 0.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid, result and value stable throughout, in_ready = 0 throughout; out_ready = 1 -> IDLE next cycle.
REQ-035 Reset pulse on the 2nd COMPARE cycle of a 4-chunk equality compare -> no out_valid, all outputs 0, in_ready = 1 the cycle after reset drops.
REQ-036 Random test with WIDTH = 64, CHUNK = 16 and WIDTH = 32, CHUNK = 1, checked against a golden model -> all 10 function codes match, and latency equals (index of the highest differing chunk counted from the top) + 1, or NCHUNK when a = b.
